// File: rtl/credit_txn_arbiter.sv
// credit_txn_arbiter
//
// Round-robin arbiter and transaction sequencer that lets several meal
// counters share one credit register. One counter is granted at a time; its
// cost is compared with the current balance and, when affordable, the
// deducted balance is written back through the register's load port. Every
// transaction ends with a one-cycle acknowledge to the granted counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          level request per counter, held until that counter's ack
//   cost         8-bit cost per counter, counter i in bits [8i+7:8i]
//   balance      current credit value from the register's data_out
//   load_enable  one-cycle write strobe to the credit register
//   data_in      new balance presented to the credit register
//   ack          one-hot, one-cycle completion pulse
//   approved     transaction outcome, meaningful only while ack != 0
//   grant_id     index of the counter being served
//   busy         high whenever a transaction is in flight
//   txn_count    number of approved transactions, saturating at 255
module credit_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] cost,
  input  logic [7:0]           balance,
  output logic                 load_enable,
  output logic [7:0]           data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 approved,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [7:0]           txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] last_id_q;
  logic [7:0]      cost_q;
  logic [7:0]      data_in_q;
  logic            result_q;
  logic [7:0]      txn_count_q;

  logic            win_valid;
  logic [ID_W-1:0] win_id;
  logic [7:0]      win_cost;
  logic            can_pay;

  // Round-robin search starting just after the last served counter, so the
  // counter served most recently has the lowest priority.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    win_valid = 1'b0;
    win_id    = '0;
    win_cost  = '0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_id_q) + off) % NUM_REQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
        win_cost  = cost[8*idx +: 8];
      end
    end
  end

  // Unsigned compare; it also gates the subtraction so it can never wrap.
  assign can_pay = (balance >= cost_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid) state_d = CHECK;
      CHECK:   state_d = can_pay ? WRITE : ACK;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= ID_W'(NUM_REQ - 1);
      cost_q      <= '0;
      data_in_q   <= '0;
      result_q    <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          // Only the latched winner is served; req changes after this edge
          // are ignored until the next return to IDLE.
          if (win_valid) begin
            grant_id_q <= win_id;
            cost_q     <= win_cost;
          end
        end
        CHECK: begin
          result_q <= can_pay;
          if (can_pay) data_in_q <= balance - cost_q;
        end
        ACK: begin
          last_id_q <= grant_id_q;
          if (result_q && txn_count_q != 8'hFF) txn_count_q <= txn_count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state and registers only.
  assign load_enable = (state_q == WRITE);
  assign ack         = (state_q == ACK) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign approved    = (state_q == ACK) && result_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign data_in     = data_in_q;
  assign txn_count   = txn_count_q;

endmodule

// File: doc/credit_txn_arbiter.md
# credit_txn_arbiter

Round-robin arbiter and transaction sequencer that shares the single mess credit register among several meal counters. It grants one counter at a time, compares the counter's meal cost against the current balance, and on approval writes the deducted balance back through the register's load port. It then returns a one-cycle acknowledge carrying approved/rejected status. It sits between the counter front-ends and the credit register; the display driver keeps reading the register output unchanged.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting counters; 2..8.
- ID_W, 2: width of grant_id; must equal ceil(log2(NUM_REQ)).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per counter; held high until that counter's ack.
- cost  input  NUM_REQ*8  meal cost of counter i in bits [8i+7:8i]; must be stable while req[i] is high.
- balance  input  8  current credit value, driven by the register's data_out.
- load_enable  output  1  write strobe to the credit register.
- data_in  output  8  new balance presented to the credit register.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- approved  output  1  valid only while ack != 0; 1 = deducted, 0 = rejected for insufficient credit.
- grant_id  output  ID_W  index of the counter currently being served.
- busy  output  1  high in every state except IDLE.
- txn_count  output  8  count of approved transactions; saturates at 255.

## Operation
- States: IDLE, CHECK, WRITE, ACK.
- IDLE:
  - If req != 0, pick the winner by round-robin, searching from index (last_id+1) mod NUM_REQ upward with wrap.
  - Latch grant_id and cost_q (the winner's 8-bit cost), then go to CHECK.
  - If req == 0, stay in IDLE.
- CHECK:
  - If balance >= cost_q (unsigned 8-bit compare): register data_in = balance - cost_q, set result = 1, go to WRITE.
  - Otherwise: set result = 0, leave data_in unchanged, go to ACK.
- WRITE: load_enable = 1 for exactly this one state cycle; go to ACK.
- ACK:
  - ack[grant_id] = 1 and approved = result for one cycle.
  - last_id <= grant_id.
  - If result = 1, txn_count increments unless already 255.
  - Go to IDLE.
- Arithmetic: subtraction cannot underflow because it is gated by the compare.
  - cost_q = 0 is approved; the write-back equals the current balance.
  - cost_q = balance is approved; the new balance is 0.
- Only the latched winner is served. Other requests, and any change in req, are ignored until the next IDLE.
- A counter that keeps req high after its ack is re-arbitrated normally. Round-robin guarantees every other pending requester is served first.
- If the winner's req drops mid-transaction, the transaction still completes and ack still pulses.
- No counter is ever granted twice in a row while another counter has req high.

## Timing
- Reset values: state IDLE, load_enable 0, data_in 0, ack 0, approved 0, grant_id 0, busy 0, txn_count 0, last_id = NUM_REQ-1 (so index 0 has first priority).
- Asserting rst_n mid-transaction immediately forces all outputs to their reset values; any pending write is abandoned.
- Approved transaction, with req sampled high at edge k in IDLE:
  - CHECK during k..k+1.
  - WRITE during k+1..k+2; the register updates at edge k+2.
  - ACK during k+2..k+3.
  - IDLE at k+3, where a new grant can be taken at edge k+3.
- Rejected transaction: CHECK at k, ACK at k+1, IDLE at k+2. load_enable never asserts.
- Throughput: one approved transaction every 4 cycles, one rejected every 3.
- busy rises the cycle after the grant edge and falls at the ACK→IDLE edge.
- load_enable, ack and approved are Moore outputs decoded from state and registers, so they are glitch-free.

## Test plan
- Reset, then balance=255 and req=0001 with cost0=40: load_enable pulses with data_in=215, ack=0001 with approved=1 three cycles after the grant, txn_count=1.
- balance=30, req=0010 with cost1=31: ack=0010 with approved=0, no load_enable pulse, latency 2 cycles, txn_count unchanged.
- req=1111 all held high, costs=1, balance tracking the register model: grants occur in order 0,1,2,3,0,…, and the balance decrements by 1 per transaction.
- Boundaries:
  - cost=0: approved, data_in equals balance.
  - cost=balance=100: approved, data_in=0.
  - Then cost=1 at balance=0: rejected.
- Preload txn_count to 255 via 255 approved cost-0 transactions, then one more approved: txn_count stays 255.
- Pull rst_n low during the WRITE state: load_enable drops immediately, all outputs return to reset values, and after release req=0100 is served with the normal latency.
